param_init_counter: RTL
=======================

PARAM_INIT_COUNTER -- requirements
Module: param_init_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, counter and output width (1..32).
REQ-002 SHALL provide parameter INIT_VAL, default 0, reset and restart value, truncated to WIDTH.
REQ-003 SHALL provide parameter STEP_W, default 8, width of io_step (STEP_W <= WIDTH).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port io_en  input  1  count enable.
REQ-007 SHALL have port io_load  input  1  synchronous load strobe.
REQ-008 SHALL have port io_load_val  input  WIDTH  load value.
REQ-009 SHALL have port io_step  input  STEP_W  unsigned increment, zero-extended.
REQ-010 SHALL have port io_limit  input  WIDTH  terminal value (inclusive).
REQ-011 SHALL have port io_mode  input  2  0=wrap, 1=saturate, 2=oneshot, 3=treated as wrap.
REQ-012 SHALL have port io_start  input  1  oneshot start/restart strobe.
REQ-013 SHALL have port io_out  output  WIDTH  current count.
REQ-014 SHALL have port io_tc  output  1  registered terminal-count pulse.
REQ-015 SHALL have port io_busy  output  1  oneshot in RUN.
REQ-016 SHALL have port io_done  output  1  oneshot in DONE.

Function
REQ-017 SHALL drive io_out directly from the count register, no combinational path from inputs.
REQ-018 SHALL apply update priority per cycle: reset > io_load > io_start (oneshot only) > count.
REQ-019 SHALL compute sum = cnt + step in WIDTH+1 bits; "over" means sum > io_limit.
REQ-020 SHALL, on io_load, set cnt <= io_load_val unchanged, even if > io_limit; oneshot FSM -> IDLE; io_tc <= 0.
REQ-021 SHALL, in wrap mode with io_en, set cnt <= over ? (sum - (io_limit+1)) truncated to WIDTH : sum; no further reduction.
REQ-022 SHALL, in saturate mode with io_en, set cnt <= over ? io_limit : sum; hold at io_limit thereafter.
REQ-023 SHALL implement oneshot FSM states IDLE, RUN, DONE; cnt counts only in RUN with io_en.
REQ-024 SHALL in IDLE or DONE on io_start set cnt <= INIT_VAL and go to RUN; io_start in RUN ignored.
REQ-025 SHALL in RUN with io_en and sum >= io_limit set cnt <= io_limit and go to DONE; otherwise cnt <= sum.
REQ-026 SHALL force FSM to IDLE whenever io_mode != 2, cnt unaffected by the transition.
REQ-027 SHALL assert io_tc for exactly the one cycle after any counting update with sum >= io_limit (all modes); io_tc 0 otherwise.
REQ-028 SHALL treat io_step = 0 as valid: cnt unchanged, io_tc per REQ-027.
REQ-029 SHALL hold cnt when io_en = 0 and no load/start/reset.
REQ-030 SHALL derive io_busy = (state==RUN), io_done = (state==DONE), both from registers.

Reset
REQ-031 SHALL on reset set cnt = INIT_VAL, FSM = IDLE, io_tc = 0, io_busy = 0, io_done = 0, overriding io_load, io_start, io_en.
REQ-032 SHALL honour reset asserted mid-count or mid-oneshot in the same edge; counting resumes the cycle after deassertion.
REQ-033 SHALL leave io_out = INIT_VAL in the first cycle after reset deasserts.

Verification
REQ-034 SHALL cover wrap: WIDTH=8, INIT_VAL=0, limit=9, step=3, en=1 -> out 0,3,6,9,2,5; io_tc high cycle after 9 reached and after 9->2 wrap.
REQ-035 SHALL cover saturate: limit=10, step=4 from 0 -> 4,8,10,10; io_tc high every cycle from the 8->10 update while en stays high.
REQ-036 SHALL cover oneshot: INIT_VAL=2, limit=7, step=2, start pulse -> out 2,4,6,7; busy 1 during RUN, done 1 after 7; second start -> out 2, busy 1.
REQ-037 SHALL cover priority: load=1, load_val=0x55, en=1, start=1 same cycle -> out 0x55 next, FSM IDLE, io_tc 0.
REQ-038 SHALL cover reset mid-run: oneshot at out=4, reset 1 cycle with load=1 -> out=INIT_VAL, busy 0, done 0, tc 0.
REQ-039 SHALL cover WIDTH=32 carry: cnt=0xFFFFFFFE, limit=0xFFFFFFFF, step=3, wrap -> out 0x00000001, io_tc 1 next cycle.

Source files
------------

// File: rtl/param_init_counter.sv
// Parameterised up-counter with wrap, saturate and oneshot modes.
// Includes a load strobe, a terminal-count pulse and oneshot busy/done status.
module param_init_counter #(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] INIT_VAL = 32'd0,
    parameter int          STEP_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_en,
    input  logic              io_load,
    input  logic [WIDTH-1:0]  io_load_val,
    input  logic [STEP_W-1:0] io_step,
    input  logic [WIDTH-1:0]  io_limit,
    input  logic [1:0]        io_mode,
    input  logic              io_start,
    output logic [WIDTH-1:0]  io_out,
    output logic              io_tc,
    output logic              io_busy,
    output logic              io_done
);

    localparam logic [WIDTH-1:0] INIT_W = INIT_VAL[WIDTH-1:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             r_tc;
    logic             w_tc_nxt;
    logic [WIDTH:0]   w_sum;
    logic             w_hit;
    logic             w_over;

    // Wrap folds the overshoot back past zero exactly once; modulo 2^WIDTH
    // arithmetic on the low bits gives the same result as the WIDTH+1 form.
    function automatic logic [WIDTH-1:0] wrap_fn(input logic [WIDTH-1:0] sum_lo,
                                                 input logic [WIDTH-1:0] lim,
                                                 input logic             over);
        return over ? (sum_lo - lim - WIDTH'(1)) : sum_lo;
    endfunction

    function automatic logic [WIDTH-1:0] sat_fn(input logic [WIDTH-1:0] sum_lo,
                                                input logic [WIDTH-1:0] lim,
                                                input logic             over);
        return over ? lim : sum_lo;
    endfunction

    assign w_sum  = {1'b0, r_cnt} + {{(WIDTH + 1 - STEP_W){1'b0}}, io_step};
    assign w_hit  = (w_sum >= {1'b0, io_limit});
    assign w_over = (w_sum >  {1'b0, io_limit});

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_state_nxt = (io_mode == 2'd2) ? r_state : S_IDLE;
        w_tc_nxt    = 1'b0;
        if (io_load) begin
            w_cnt_nxt   = io_load_val;
            w_state_nxt = S_IDLE;
        end else if (io_mode == 2'd2) begin
            if (io_start && (r_state != S_RUN)) begin
                w_cnt_nxt   = INIT_W;
                w_state_nxt = S_RUN;
            end else if ((r_state == S_RUN) && io_en) begin
                w_tc_nxt = w_hit;
                if (w_hit) begin
                    w_cnt_nxt   = io_limit;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = w_sum[WIDTH-1:0];
                end
            end
        end else if (io_en) begin
            w_tc_nxt  = w_hit;
            w_cnt_nxt = (io_mode == 2'd1) ? sat_fn(w_sum[WIDTH-1:0], io_limit, w_over)
                                          : wrap_fn(w_sum[WIDTH-1:0], io_limit, w_over);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= INIT_W;
            r_state <= S_IDLE;
            r_tc    <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    assign io_out  = r_cnt;
    assign io_tc   = r_tc;
    assign io_busy = (r_state == S_RUN);
    assign io_done = (r_state == S_DONE);

endmodule
